// File: rtl/loop_address_unit_pkg.sv
// Shared opcodes, FSM encodings and default sizes for the loop address unit.
// No logic; latency and backpressure are defined by the modules that import it.
package loop_address_unit_pkg;

  localparam int DEF_LOOP_DEPTH = 8;
  localparam int DEF_NUM_APU    = 4;
  localparam int DEF_ADDR_W     = 18;

  typedef enum logic [1:0] {
    LOOP_CMD_START = 2'd0,
    LOOP_CMD_END   = 2'd1,
    LOOP_CMD_CLEAR = 2'd2,
    LOOP_CMD_RSVD  = 2'd3
  } loop_cmd_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_ACC    = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apu_mac_lane.sv
// One address channel: base + per-level coefficients, sequential multiply-accumulate.
// Latency: one level per acc_step, addr updates on acc_last; no backpressure (driven by top FSM).
module apu_mac_lane
  import loop_address_unit_pkg::*;
#(
  parameter int LOOP_DEPTH     = DEF_LOOP_DEPTH,
  parameter int LOG_LOOP_DEPTH = 3,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coef_we,
  input  logic                      base_we,
  input  logic [LOG_LOOP_DEPTH-1:0] cfg_level,
  input  logic [ADDR_W-1:0]         cfg_value,
  input  logic                      acc_init,
  input  logic                      acc_step,
  input  logic                      acc_last,
  input  logic [LOG_LOOP_DEPTH-1:0] acc_level,
  input  logic [CNT_W-1:0]          acc_var,
  output logic [ADDR_W-1:0]         addr
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] coef_q [LOOP_DEPTH];
  logic [ADDR_W-1:0] acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] var_w;
  logic [ADDR_W-1:0] term;

  // Only the low ADDR_W bits of each operand affect the truncated product.
  always_comb begin
    var_w = ADDR_W'(acc_var);
    term  = coef_q[acc_level] * var_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      acc_q  <= '0;
      addr_q <= '0;
      for (int k = 0; k < LOOP_DEPTH; k++) begin
        coef_q[k] <= '0;
      end
    end else begin
      if (base_we) begin
        base_q <= cfg_value;
      end
      if (coef_we) begin
        coef_q[cfg_level] <= cfg_value;
      end
      if (acc_init) begin
        acc_q <= base_q;
      end else if (acc_step) begin
        acc_q <= acc_q + term;
      end
      if (acc_last) begin
        addr_q <= acc_q + term;
      end
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/loop_address_unit.sv
// Loop stack (START/END/CLEAR) plus NUM_APU affine address channels over the active levels.
// Latency: rsp_valid LOOP_DEPTH+3 cycles after accept; cmd_ready low from accept until back in IDLE.
module loop_address_unit
  import loop_address_unit_pkg::*;
#(
  parameter int LOOP_DEPTH     = DEF_LOOP_DEPTH,
  parameter int LOG_LOOP_DEPTH = 3,
  parameter int NUM_LOOPS      = 32,
  parameter int LOG_NUM_LOOPS  = 5,
  parameter int NUM_APU        = DEF_NUM_APU,
  parameter int LOG_NUM_APU    = 2,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_count_we,
  input  logic [LOG_NUM_LOOPS-1:0]  cfg_loop_idx,
  input  logic [CNT_W-1:0]          cfg_count,
  input  logic                      cfg_coef_we,
  input  logic                      cfg_base_we,
  input  logic [LOG_NUM_APU-1:0]    cfg_apu_idx,
  input  logic [LOG_LOOP_DEPTH-1:0] cfg_level,
  input  logic [ADDR_W-1:0]         cfg_value,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [LOG_NUM_LOOPS-1:0]  cmd_loop_idx,
  output logic                      rsp_valid,
  output logic                      rsp_jump,
  output logic                      rsp_done,
  output logic [NUM_APU*ADDR_W-1:0] addr_out,
  output logic                      addr_valid,
  output logic [LOG_LOOP_DEPTH:0]   depth_out,
  output logic                      error_overflow,
  output logic                      error_underflow
);

  logic [1:0]               state_q;
  loop_cmd_e                op_q;
  logic [LOG_NUM_LOOPS-1:0] idx_q;
  logic [CNT_W-1:0]         count_tbl [NUM_LOOPS];
  logic [CNT_W-1:0]         var_stk   [LOOP_DEPTH];
  logic [CNT_W-1:0]         lim_stk   [LOOP_DEPTH];
  logic [LOG_LOOP_DEPTH:0]  depth_q;
  logic [LOG_LOOP_DEPTH:0]  acc_cnt_q;
  logic                     jump_q;
  logic                     done_q;
  logic                     ovf_q;
  logic                     unf_q;

  logic                      cfg_en;
  logic                      stk_full;
  logic [LOG_LOOP_DEPTH-1:0] top_idx;
  logic [LOG_LOOP_DEPTH-1:0] push_idx;
  logic [CNT_W-1:0]          cnt_sel;
  logic [CNT_W:0]            var_inc;
  logic                      acc_init;
  logic                      acc_step;
  logic                      acc_last;
  logic [LOG_LOOP_DEPTH-1:0] acc_level;
  logic [CNT_W-1:0]          acc_var;

  assign cfg_en   = (state_q == ST_IDLE);
  assign stk_full = (depth_q == (LOG_LOOP_DEPTH+1)'(LOOP_DEPTH));
  assign top_idx  = LOG_LOOP_DEPTH'(depth_q - 1'b1);
  assign push_idx = LOG_LOOP_DEPTH'(depth_q);
  assign cnt_sel  = count_tbl[idx_q];
  assign var_inc  = {1'b0, var_stk[top_idx]} + (CNT_W+1)'(1);

  // ACC step 0 loads base; steps 1..LOOP_DEPTH fold in levels 0..LOOP_DEPTH-1.
  assign acc_init  = (state_q == ST_ACC) && (acc_cnt_q == '0);
  assign acc_step  = (state_q == ST_ACC) && (acc_cnt_q != '0);
  assign acc_last  = (state_q == ST_ACC) && (acc_cnt_q == (LOG_LOOP_DEPTH+1)'(LOOP_DEPTH));
  assign acc_level = LOG_LOOP_DEPTH'(acc_cnt_q - 1'b1);
  // Popped levels keep stale values in the stack, so gate by current depth.
  assign acc_var   = ({1'b0, acc_level} < depth_q) ? var_stk[acc_level] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= LOOP_CMD_START;
      idx_q     <= '0;
      depth_q   <= '0;
      acc_cnt_q <= '0;
      jump_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        count_tbl[i] <= '0;
      end
      for (int k = 0; k < LOOP_DEPTH; k++) begin
        var_stk[k] <= '0;
        lim_stk[k] <= '0;
      end
    end else begin
      if (cfg_en && cfg_count_we) begin
        count_tbl[cfg_loop_idx] <= cfg_count;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= loop_cmd_e'(cmd_op);
            idx_q   <= cmd_loop_idx;
            jump_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          acc_cnt_q <= '0;
          state_q   <= ST_ACC;
          case (op_q)
            LOOP_CMD_START: begin
              if (cnt_sel == '0) begin
                done_q <= 1'b1;
              end else if (stk_full) begin
                ovf_q <= 1'b1;
              end else begin
                var_stk[push_idx] <= '0;
                lim_stk[push_idx] <= cnt_sel;
                depth_q           <= depth_q + 1'b1;
              end
            end
            LOOP_CMD_END: begin
              if (depth_q == '0) begin
                unf_q <= 1'b1;
              end else if (var_inc < {1'b0, lim_stk[top_idx]}) begin
                var_stk[top_idx] <= var_inc[CNT_W-1:0];
                jump_q           <= 1'b1;
              end else begin
                depth_q <= depth_q - 1'b1;
                done_q  <= 1'b1;
              end
            end
            default: begin
              depth_q <= '0;
              ovf_q   <= 1'b0;
              unf_q   <= 1'b0;
            end
          endcase
        end
        ST_ACC: begin
          if (acc_last) begin
            state_q <= ST_RESP;
          end else begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar a = 0; a < NUM_APU; a++) begin : g_lane
    apu_mac_lane #(
      .LOOP_DEPTH     (LOOP_DEPTH),
      .LOG_LOOP_DEPTH (LOG_LOOP_DEPTH),
      .ADDR_W         (ADDR_W),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .coef_we   (cfg_en && cfg_coef_we && (cfg_apu_idx == LOG_NUM_APU'(a))),
      .base_we   (cfg_en && cfg_base_we && (cfg_apu_idx == LOG_NUM_APU'(a))),
      .cfg_level (cfg_level),
      .cfg_value (cfg_value),
      .acc_init  (acc_init),
      .acc_step  (acc_step),
      .acc_last  (acc_last),
      .acc_level (acc_level),
      .acc_var   (acc_var),
      .addr      (addr_out[a*ADDR_W +: ADDR_W])
    );
  end

  assign cmd_ready       = (state_q == ST_IDLE);
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_jump        = rsp_valid && jump_q;
  assign rsp_done        = rsp_valid && done_q;
  assign addr_valid      = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign depth_out       = depth_q;
  assign error_overflow  = ovf_q;
  assign error_underflow = unf_q;

endmodule

// File: tb/tb_loop_address_unit.sv
// Scoreboarded random + directed bench for loop_address_unit against an arithmetic loop-nest model.
module tb_loop_address_unit;

  localparam int LD = 8;
  localparam int NL = 32;
  localparam int NA = 4;
  localparam int AW = 18;
  localparam int CW = 16;

  logic           clk;
  logic           reset;
  logic           cfg_count_we;
  logic [4:0]     cfg_loop_idx;
  logic [CW-1:0]  cfg_count;
  logic           cfg_coef_we;
  logic           cfg_base_we;
  logic [1:0]     cfg_apu_idx;
  logic [2:0]     cfg_level;
  logic [AW-1:0]  cfg_value;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [4:0]     cmd_loop_idx;
  logic           rsp_valid;
  logic           rsp_jump;
  logic           rsp_done;
  logic [NA*AW-1:0] addr_out;
  logic           addr_valid;
  logic [3:0]     depth_out;
  logic           error_overflow;
  logic           error_underflow;

  loop_address_unit dut (
    .clk(clk), .reset(reset),
    .cfg_count_we(cfg_count_we), .cfg_loop_idx(cfg_loop_idx), .cfg_count(cfg_count),
    .cfg_coef_we(cfg_coef_we), .cfg_base_we(cfg_base_we), .cfg_apu_idx(cfg_apu_idx),
    .cfg_level(cfg_level), .cfg_value(cfg_value),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_loop_idx(cmd_loop_idx),
    .rsp_valid(rsp_valid), .rsp_jump(rsp_jump), .rsp_done(rsp_done),
    .addr_out(addr_out), .addr_valid(addr_valid), .depth_out(depth_out),
    .error_overflow(error_overflow), .error_underflow(error_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic           jump;
    logic           done;
    logic           ovf;
    logic           unf;
    logic [3:0]     depth;
    logic [NA*AW-1:0] addr;
    logic [31:0]    at;
  } exp_t;
  exp_t sb[$];

  // Reference model: the loop nest as plain integers.
  int unsigned cnt_m  [NL];
  int unsigned base_m [NA];
  int unsigned coef_m [NA][LD];
  int unsigned var_m  [LD];
  int unsigned lim_m  [LD];
  int          dep_m;
  bit          ovf_m, unf_m;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NA*AW-1:0] model_addrs();
    logic [NA*AW-1:0] r;
    longint s;
    r = '0;
    for (int a = 0; a < NA; a++) begin
      s = longint'(base_m[a]);
      for (int d = 0; d < dep_m; d++) s += longint'(coef_m[a][d]) * longint'(var_m[d]);
      r[a*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) cnt_m[i] = 0;
    for (int a = 0; a < NA; a++) begin
      base_m[a] = 0;
      for (int d = 0; d < LD; d++) coef_m[a][d] = 0;
    end
    dep_m = 0; ovf_m = 0; unf_m = 0;
  endtask

  task automatic idle_inputs();
    cfg_count_we = 0; cfg_coef_we = 0; cfg_base_we = 0;
    cfg_loop_idx = 0; cfg_count = 0; cfg_apu_idx = 0; cfg_level = 0; cfg_value = 0;
    cmd_valid = 0; cmd_op = 0; cmd_loop_idx = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
    end
  endtask

  task automatic wr_count(int idx, int unsigned v);
    wait_ready();
    cfg_count_we = 1; cfg_loop_idx = 5'(idx); cfg_count = CW'(v);
    cnt_m[idx] = v & 32'hFFFF;
    @(negedge clk); cfg_count_we = 0;
  endtask

  task automatic wr_coef(int a, int l, int unsigned v);
    wait_ready();
    cfg_coef_we = 1; cfg_apu_idx = 2'(a); cfg_level = 3'(l); cfg_value = AW'(v);
    coef_m[a][l] = v & 32'h3FFFF;
    @(negedge clk); cfg_coef_we = 0;
  endtask

  task automatic wr_base(int a, int unsigned v);
    wait_ready();
    cfg_base_we = 1; cfg_apu_idx = 2'(a); cfg_value = AW'(v);
    base_m[a] = v & 32'h3FFFF;
    @(negedge clk); cfg_base_we = 0;
  endtask

  // Issues one command (optionally with a same-cycle count write) and queues its expected response.
  task automatic send(int op, int idx, bit hold = 0, bit wcnt = 0, int unsigned wval = 0);
    exp_t e;
    wait_ready();
    cmd_valid = 1; cmd_op = 2'(op); cmd_loop_idx = 5'(idx);
    if (wcnt) begin
      cfg_count_we = 1; cfg_loop_idx = 5'(idx); cfg_count = CW'(wval);
      cnt_m[idx] = wval & 32'hFFFF;
    end
    e = '0;
    case (op)
      0: begin
        if (cnt_m[idx] == 0) e.done = 1;
        else if (dep_m == LD) ovf_m = 1;
        else begin var_m[dep_m] = 0; lim_m[dep_m] = cnt_m[idx]; dep_m++; end
      end
      1: begin
        if (dep_m == 0) unf_m = 1;
        else if (var_m[dep_m-1] + 1 < lim_m[dep_m-1]) begin var_m[dep_m-1]++; e.jump = 1; end
        else begin dep_m--; e.done = 1; end
      end
      default: begin dep_m = 0; ovf_m = 0; unf_m = 0; end
    endcase
    e.ovf = ovf_m; e.unf = unf_m; e.depth = 4'(dep_m); e.addr = model_addrs();
    e.at = edge_cnt + LD + 3;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) cmd_valid = 0;
    // Config writes while busy must be ignored.
    cfg_count_we = 1; cfg_loop_idx = 5'($urandom_range(0, NL-1)); cfg_count = CW'($urandom);
    cfg_coef_we = 1; cfg_base_we = 1; cfg_apu_idx = 2'($urandom); cfg_level = 3'($urandom);
    cfg_value = AW'($urandom);
    @(negedge clk);
    cfg_count_we = 0; cfg_coef_we = 0; cfg_base_we = 0;
  endtask

  // Monitor: every response is popped and compared against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: rsp_valid=1 jump=%0d done=%0d with empty scoreboard", rsp_jump, rsp_done);
      end else begin
        e = sb.pop_front();
        check("rsp_latency", edge_cnt, e.at);
        check("rsp_jump", rsp_jump, e.jump);
        check("rsp_done", rsp_done, e.done);
        check("rsp_exclusive", rsp_jump & rsp_done, 0);
        check("rsp_depth", depth_out, e.depth);
        check("rsp_ovf", error_overflow, e.ovf);
        check("rsp_unf", error_underflow, e.unf);
        check("rsp_addr_valid", addr_valid, 1);
        for (int a = 0; a < NA; a++)
          check($sformatf("rsp_addr%0d", a), addr_out[a*AW +: AW], e.addr[a*AW +: AW]);
      end
    end
  end

  task automatic do_reset();
    reset = 1;
    sb.delete();
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int r;
    idle_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_depth", depth_out, 0);
    check("rst_addr_zero", addr_out == '0, 1);
    check("rst_addr_valid", addr_valid, 1);
    check("rst_ovf", error_overflow, 0);
    check("rst_unf", error_underflow, 0);

    // Single loop: addr0 = 3 + 2*var
    wr_count(0, 3); wr_base(0, 3); wr_coef(0, 0, 2);
    send(0, 0); drain(); check("single_start_addr0", addr_out[AW-1:0], 3);
    send(1, 0); drain(); check("single_end1_addr0", addr_out[AW-1:0], 5);
    send(1, 0); drain(); check("single_end2_addr0", addr_out[AW-1:0], 7);
    send(1, 0); drain(); check("single_end3_addr0", addr_out[AW-1:0], 3);
    check("single_depth", depth_out, 0);

    // Nested 2x3: addr0 = 16*outer + inner
    do_reset();
    wr_count(0, 2); wr_count(1, 3); wr_coef(0, 0, 16); wr_coef(0, 1, 1);
    send(0, 0);
    for (int o = 0; o < 2; o++) begin
      send(0, 1);
      for (int i = 0; i < 3; i++) send(1, 1);
      send(1, 0);
    end
    drain();
    check("nested_depth", depth_out, 0);
    check("nested_addr0", addr_out[AW-1:0], 0);

    // Overflow then CLEAR
    do_reset();
    wr_count(1, 1); wr_base(0, 5);
    for (int i = 0; i < 9; i++) send(0, 1);
    drain();
    check("ovf_flag", error_overflow, 1);
    check("ovf_depth", depth_out, 8);
    send(2, 0); drain();
    check("clear_depth", depth_out, 0);
    check("clear_ovf", error_overflow, 0);
    check("clear_addr0", addr_out[AW-1:0], 5);

    // Zero-trip and underflow
    send(0, 2); drain();
    check("zero_trip_depth", depth_out, 0);
    send(1, 0); drain();
    check("underflow_flag", error_underflow, 1);

    // Back-pressure: cmd_valid held through the whole operation
    wr_count(3, 2);
    send(0, 3, 1);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      check("bp_ready_low", cmd_ready, 0);
      if (rsp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    cmd_valid = 0;
    check("bp_rsp_seen", seen, 1);
    repeat (15) @(negedge clk);
    check("bp_single_accept", depth_out, dep_m);

    // Reset in the middle of ACC
    send(0, 3);
    repeat (3) @(negedge clk);
    reset = 1;
    sb.delete();
    model_reset();
    @(negedge clk);
    reset = 0;
    check("midrst_ready", cmd_ready, 1);
    check("midrst_depth", depth_out, 0);
    check("midrst_rsp", rsp_valid, 0);
    check("midrst_addr_zero", addr_out == '0, 1);
    repeat (15) @(negedge clk);
    check("midrst_quiet", cmd_ready, 1);

    // Randomised traffic
    for (int i = 0; i < NL; i++) wr_count(i, $urandom_range(0, 3));
    for (int a = 0; a < NA; a++) begin
      wr_base(a, $urandom);
      for (int d = 0; d < LD; d++) wr_coef(a, d, $urandom);
    end
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) wr_count($urandom_range(0, NL-1), $urandom_range(0, 4));
      else if (r < 7) wr_coef($urandom_range(0, NA-1), $urandom_range(0, LD-1), $urandom);
      else if (r < 10) wr_base($urandom_range(0, NA-1), $urandom);
      r = $urandom_range(0, 99);
      if (r < 45) send(0, $urandom_range(0, NL-1), 0, ($urandom_range(0, 6) == 0), $urandom_range(0, 3));
      else if (r < 88) send(1, 0);
      else if (r < 94) send(2, 0);
      else send(3, 0);
    end
    drain();
    check("final_depth", depth_out, dep_m);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
